// File: rtl/hsid_fifo_ctrl.sv
// hsid_fifo_ctrl: loads a reference vector into one hsid_fifo and
// replays it cfg_passes times to the distance datapath.
module hsid_fifo_ctrl #(
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PASS_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FIFO_ADDR_WIDTH:0]   cfg_len,
  input  logic [PASS_WIDTH-1:0]      cfg_passes,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       s_valid,
  input  logic [WORD_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [WORD_WIDTH-1:0]      m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       fifo_wr_en,
  output logic                       fifo_rd_en,
  output logic                       fifo_loop_en,
  output logic                       fifo_clear,
  output logic [WORD_WIDTH-1:0]      fifo_data_in,
  output logic [FIFO_ADDR_WIDTH-1:0] fifo_af_threshold,
  input  logic                       fifo_full,
  input  logic                       fifo_almost_full,
  input  logic                       fifo_empty,
  input  logic [WORD_WIDTH-1:0]      fifo_data_out
);

  localparam int FIFO_DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int LW         = FIFO_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_LOOP,
    S_FLUSH,
    S_ABORT
  } state_t;

  state_t                state;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         wr_cnt;
  logic [LW-1:0]         word_cnt;
  logic [PASS_WIDTH-1:0] passes_q;
  logic [PASS_WIDTH-1:0] pass_cnt;

  logic cfg_ok;
  logic final_pass;
  logic issue;
  logic word_wrap;
  logic last_write;
  logic hs;

  assign cfg_ok = (cfg_len != '0) &&
                  (cfg_len <= DEPTH_L) &&
                  (cfg_passes != '0);

  assign final_pass = (pass_cnt == passes_q - PASS_WIDTH'(1));
  assign word_wrap  = (word_cnt == len_q - LW'(1));
  assign hs         = m_valid && m_ready;

  // One-slot output stage: refill only when the slot is free or draining.
  assign issue = (state == S_LOOP) && !fifo_empty &&
                 (!m_valid || m_ready);

  assign s_ready    = (state == S_FILL) && !fifo_full;
  assign fifo_wr_en = s_valid && s_ready;
  assign last_write = fifo_wr_en && (wr_cnt + LW'(1) == len_q);

  assign fifo_loop_en = issue && !final_pass;
  assign fifo_rd_en   = issue && final_pass;
  assign fifo_clear   = (state == S_CLEAR) || (state == S_ABORT);

  assign busy         = (state != S_IDLE);
  assign fifo_data_in = s_data;
  assign m_data       = fifo_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      len_q             <= '0;
      passes_q          <= '0;
      wr_cnt            <= '0;
      word_cnt          <= '0;
      pass_cnt          <= '0;
      m_valid           <= 1'b0;
      m_last            <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      fifo_af_threshold <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (issue) begin
        m_valid <= 1'b1;
        m_last  <= word_wrap;
      end else if (hs) begin
        m_valid <= 1'b0;
      end

      // Abort overrides every other transition of a running job.
      if (abort && state != S_IDLE) begin
        state   <= S_ABORT;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                len_q             <= cfg_len;
                passes_q          <= cfg_passes;
                fifo_af_threshold <=
                  FIFO_ADDR_WIDTH'(cfg_len - LW'(1));
                state             <= S_CLEAR;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            wr_cnt   <= '0;
            word_cnt <= '0;
            pass_cnt <= '0;
            state    <= S_FILL;
          end
          S_FILL: begin
            if (fifo_wr_en) begin
              wr_cnt <= wr_cnt + LW'(1);
            end
            if (last_write) begin
              state <= S_LOOP;
            end
          end
          S_LOOP: begin
            if (issue) begin
              if (word_wrap) begin
                word_cnt <= '0;
                pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                if (final_pass) begin
                  state <= S_FLUSH;
                end
              end else begin
                word_cnt <= word_cnt + LW'(1);
              end
            end
          end
          S_FLUSH: begin
            if (hs) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_ABORT: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The FIFO must have reached the threshold when FILL ends and be
  // drained when the job completes.
  always @(posedge clk) begin
    if (!rst && state == S_FILL && last_write && !abort) begin
      assert (fifo_almost_full);
    end
    if (!rst && state == S_FLUSH && hs && !abort) begin
      assert (fifo_empty);
    end
  end

endmodule

// File: tb/tb_hsid_fifo_ctrl.sv
// tb_hsid_fifo_ctrl: directed vectors for hsid_fifo_ctrl against a
// small behavioural FIFO.
module tb_hsid_fifo_ctrl;

  localparam int WW = 16;
  localparam int AW = 4;
  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW:0]   cfg_len;
  logic [PW-1:0] cfg_passes;
  logic          busy;
  logic          done;
  logic          err;
  logic          s_valid;
  logic [WW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [WW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic          fifo_loop_en;
  logic          fifo_clear;
  logic [WW-1:0] fifo_data_in;
  logic [AW-1:0] fifo_af_threshold;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_empty;
  logic [WW-1:0] fifo_data_out;

  hsid_fifo_ctrl #(
    .WORD_WIDTH(WW),
    .FIFO_ADDR_WIDTH(AW),
    .PASS_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg_len(cfg_len),
    .cfg_passes(cfg_passes),
    .busy(busy),
    .done(done),
    .err(err),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en),
    .fifo_loop_en(fifo_loop_en),
    .fifo_clear(fifo_clear),
    .fifo_data_in(fifo_data_in),
    .fifo_af_threshold(fifo_af_threshold),
    .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: data_out only changes on a read or loop strobe.
  logic [WW-1:0] mem [16];
  logic [3:0]    rp;
  logic [3:0]    wp;
  logic [4:0]    cnt;

  assign fifo_full        = (cnt == 5'd16);
  assign fifo_empty       = (cnt == 5'd0);
  assign fifo_almost_full = (cnt >= {1'b0, fifo_af_threshold});

  always @(posedge clk) begin
    if (rst || fifo_clear) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      if (rst) fifo_data_out <= '0;
    end else if (fifo_wr_en && cnt < 5'd16) begin
      mem[wp] <= fifo_data_in;
      wp      <= wp + 4'd1;
      cnt     <= cnt + 5'd1;
    end else if (fifo_loop_en && cnt > 5'd0) begin
      mem[wp]       <= mem[rp];
      fifo_data_out <= mem[rp];
      rp            <= rp + 4'd1;
      wp            <= wp + 4'd1;
    end else if (fifo_rd_en && cnt > 5'd0) begin
      fifo_data_out <= mem[rp];
      rp            <= rp + 4'd1;
      cnt           <= cnt - 5'd1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int len;
    int passes;
    bit abrt;
    bit exp_err;
    bit exp_busy;
  } cfg_t;

  typedef struct {
    int len;
    int passes;
    bit rdy_tog;
    bit vld_gap;
    int abort_k;
  } job_t;

  cfg_t cfgs [5];
  job_t jobs [5];

  task automatic run_job(input job_t j);
    int c, wr, k, iss, rc, nloop, nrd, ndone, first_hs, last_hs;
    bit aborted;
    bit [3:0] rpat;
    logic [WW-1:0] expw;
    rpat = 4'b1001;
    aborted = 0;
    k = 0; iss = 0; nloop = 0; nrd = 0; ndone = 0;
    first_hs = -1; last_hs = -1;
    cfg_len    = (AW+1)'(j.len);
    cfg_passes = PW'(j.passes);
    start = 1'b1;
    @(negedge clk);
    chk("pre_busy", busy, 0);
    step();
    start = 1'b0;
    c = 1;
    @(negedge clk);
    chk("clear", fifo_clear, 1);
    chk("clear_sready", s_ready, 0);
    step();
    c = 2;
    wr = 0;
    while (wr < j.len && c < 200) begin
      s_valid = j.vld_gap ? (c % 4 != 3) : 1'b1;
      s_data  = WW'(16'hA0 + wr);
      @(negedge clk);
      chk("wr_en", fifo_wr_en, s_valid);
      chk("data_in", fifo_data_in, s_data);
      if (fifo_wr_en) wr++;
      step();
      c++;
    end
    chk("fill_words", wr, j.len);
    rc = 0;
    while (k < j.len * j.passes && rc < 400 && !aborted) begin
      m_ready = j.rdy_tog ? rpat[rc % 4] : 1'b1;
      abort   = (j.abort_k >= 0 && iss == j.abort_k);
      s_valid = (rc == 0);
      s_data  = 16'hEE;
      @(negedge clk);
      if (rc == 0) begin
        chk("loop_entry", fifo_loop_en | fifo_rd_en, 1);
        chk("no_wr_loop", fifo_wr_en, 0);
        chk("af_thr", fifo_af_threshold, j.len - 1);
        if (!j.vld_gap) chk("loop_cycle", c, j.len + 2);
      end
      chk("strobe_excl", fifo_loop_en & fifo_rd_en, 0);
      if (fifo_loop_en) nloop++;
      if (fifo_rd_en) nrd++;
      if (done) ndone++;
      if (m_valid) begin
        expw = WW'(16'hA0 + (k % j.len));
        chk("m_data", m_data, expw);
        if (m_ready) begin
          chk("m_last", m_last, (k % j.len) == j.len - 1);
          if (first_hs < 0) first_hs = rc;
          last_hs = rc;
          k++;
        end
      end
      if (fifo_loop_en | fifo_rd_en) iss++;
      if (abort) aborted = 1;
      step();
      rc++;
    end
    abort   = 1'b0;
    m_ready = 1'b0;
    s_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk("abort_clear", fifo_clear, 1);
      chk("abort_mvalid", m_valid, 0);
      chk("abort_done", done, 0);
      step();
      @(negedge clk);
      chk("abort_idle", busy, 0);
      chk("abort_done2", done | fifo_clear, 0);
      chk("abort_early_done", ndone, 0);
    end else begin
      chk("words", k, j.len * j.passes);
      @(negedge clk);
      chk("done", done, 1);
      chk("done_idle", busy, 0);
      chk("done_empty", fifo_empty, 1);
      chk("early_done", ndone, 0);
      chk("n_loop", nloop, (j.passes - 1) * j.len);
      chk("n_rd", nrd, j.len);
      if (!j.rdy_tog) begin
        chk("first_mvalid", first_hs, 1);
        chk("no_bubble", last_hs - first_hs, j.len * j.passes - 1);
      end
      step();
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    cfgs[0] = '{len: 0,  passes: 3, abrt: 0, exp_err: 1, exp_busy: 0};
    cfgs[1] = '{len: 17, passes: 3, abrt: 0, exp_err: 1, exp_busy: 0};
    cfgs[2] = '{len: 4,  passes: 0, abrt: 0, exp_err: 1, exp_busy: 0};
    cfgs[3] = '{len: 31, passes: 0, abrt: 0, exp_err: 1, exp_busy: 0};
    cfgs[4] = '{len: 16, passes: 1, abrt: 1, exp_err: 0, exp_busy: 1};

    jobs[0] = '{len: 4,  passes: 3, rdy_tog: 0, vld_gap: 0, abort_k: -1};
    jobs[1] = '{len: 16, passes: 1, rdy_tog: 0, vld_gap: 0, abort_k: -1};
    jobs[2] = '{len: 3,  passes: 2, rdy_tog: 1, vld_gap: 0, abort_k: -1};
    jobs[3] = '{len: 3,  passes: 1, rdy_tog: 0, vld_gap: 1, abort_k: -1};
    jobs[4] = '{len: 4,  passes: 3, rdy_tog: 0, vld_gap: 0, abort_k: 6};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_len = '0;
    cfg_passes = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, err, m_valid, m_last, s_ready}, 0);
    chk("rst_strobes",
        {fifo_wr_en, fifo_rd_en, fifo_loop_en, fifo_clear}, 0);
    chk("rst_thr", fifo_af_threshold, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      cfg_len    = (AW+1)'(cfgs[i].len);
      cfg_passes = PW'(cfgs[i].passes);
      start = 1'b1;
      abort = cfgs[i].abrt;
      step();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("cfg_err", err, cfgs[i].exp_err);
      chk("cfg_busy", busy, cfgs[i].exp_busy);
      chk("cfg_clear", fifo_clear, cfgs[i].exp_busy);
      step();
      @(negedge clk);
      chk("cfg_err_pulse", err, 0);
      if (cfgs[i].exp_busy) begin
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        @(negedge clk);
        chk("cfg_abort_idle", busy, 0);
      end
      step();
    end

    for (int i = 0; i < 5; i++) begin
      run_job(jobs[i]);
    end

    cfg_len = 5'd8;
    cfg_passes = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    s_valid = 1'b1;
    s_data = 16'h55;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sready", {s_ready, fifo_wr_en}, 0);
    chk("mid_rst_thr", fifo_af_threshold, 0);
    chk("mid_rst_mvalid", m_valid, 0);
    step();
    rst = 1'b0;
    s_valid = 1'b0;
    step();
    run_job(jobs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
